// File: rtl/eth_pkg.sv
// +----------------------------------------------------------------------------+
// | eth_pkg : shared widths and write-FSM states for the ethernet rx path      |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package eth_pkg;
  localparam int ETH_BYTE_W = 8;

  typedef enum logic [0:0] {
    WR_NORMAL = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_e;
endpackage

`default_nettype wire

// File: rtl/eth_sdp_ram.sv
// +----------------------------------------------------------------------------+
// | eth_sdp_ram : simple dual-port RAM, one clock, registered read port         |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module eth_sdp_ram #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // The read register doubles as the stream output register, so it holds
  // its value whenever no read is issued and clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/eth_rx_frame_fifo.sv
// +----------------------------------------------------------------------------+
// | eth_rx_frame_fifo : store-and-forward rx frame FIFO, drops bad/overflowed  |
// | frames, forwards only complete frames. rev 1.0                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module eth_rx_frame_fifo
  import eth_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DROP_BAD_FRAME = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ETH_BYTE_W-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [ETH_BYTE_W-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame,
  output logic [ADDR_WIDTH:0]   status_fill
);

  localparam int              PW      = ADDR_WIDTH + 1;
  localparam int              RAM_W   = (DROP_BAD_FRAME != 0) ? ETH_BYTE_W + 1 : ETH_BYTE_W + 2;
  localparam logic [PW-1:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0]   PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_cur_q, wr_cur_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fill_d;
  logic          valid_q, valid_d;
  logic          good_d, bad_d, ovf_d;
  logic          good_q, bad_q, ovf_q;
  logic [PW-1:0] fill_q;
  logic          wr_en, full, rd_load;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;

  assign full    = (wr_cur_q - rd_ptr_q) == DEPTH;
  assign rd_load = (rd_ptr_q != wr_commit_q) && (!valid_q || m_axis_tready);

  always_comb begin
    state_d     = state_q;
    wr_cur_d    = wr_cur_q;
    wr_commit_d = wr_commit_q;
    wr_en       = 1'b0;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    ovf_d       = 1'b0;
    if (s_axis_tvalid) begin
      case (state_q)
        WR_NORMAL: begin
          if (full) begin
            if (s_axis_tlast) begin
              wr_cur_d = wr_commit_q;
              ovf_d    = 1'b1;
            end else begin
              state_d = WR_DROP;
            end
          end else begin
            wr_en    = 1'b1;
            wr_cur_d = wr_cur_q + PTR_ONE;
            if (s_axis_tlast) begin
              if (s_axis_tuser && (DROP_BAD_FRAME != 0)) begin
                wr_cur_d = wr_commit_q;
                bad_d    = 1'b1;
              end else begin
                wr_commit_d = wr_cur_q + PTR_ONE;
                good_d      = 1'b1;
              end
            end
          end
        end
        WR_DROP: begin
          if (s_axis_tlast) begin
            wr_cur_d = wr_commit_q;
            ovf_d    = 1'b1;
            state_d  = WR_NORMAL;
          end
        end
        default: state_d = WR_NORMAL;
      endcase
    end
  end

  // rd_ptr counts bytes already moved into the output register, so the
  // fill adds back the one still waiting for its handshake.
  always_comb begin
    rd_ptr_d = rd_load ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    valid_d  = rd_load | (valid_q & ~m_axis_tready);
    fill_d   = wr_commit_d - rd_ptr_d + {{ADDR_WIDTH{1'b0}}, valid_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WR_NORMAL;
      wr_cur_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      valid_q     <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_cur_q    <= wr_cur_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      valid_q     <= valid_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      ovf_q       <= ovf_d;
      fill_q      <= fill_d;
    end
  end

  generate
    if (DROP_BAD_FRAME != 0) begin : g_drop_bad
      assign ram_wdata    = {s_axis_tlast, s_axis_tdata};
      assign m_axis_tuser = 1'b0;
    end else begin : g_keep_bad
      assign ram_wdata    = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
      assign m_axis_tuser = ram_rdata[ETH_BYTE_W+1];
    end
  endgenerate

  eth_sdp_ram #(
    .DATA_W (RAM_W),
    .ADDR_W (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_cur_q[ADDR_WIDTH-1:0]),
    .wr_data_i (ram_wdata),
    .rd_en_i   (rd_load),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (ram_rdata)
  );

  assign m_axis_tdata      = ram_rdata[ETH_BYTE_W-1:0];
  assign m_axis_tlast      = ram_rdata[ETH_BYTE_W];
  assign m_axis_tvalid     = valid_q;
  assign status_overflow   = ovf_q;
  assign status_bad_frame  = bad_q;
  assign status_good_frame = good_q;
  assign status_fill       = fill_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_rx_frame_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_eth_rx_frame_fifo : directed self-checking bench for eth_rx_frame_fifo  |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_eth_rx_frame_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        status_overflow;
  logic        status_bad_frame;
  logic        status_good_frame;
  logic [12:0] status_fill;

  eth_rx_frame_fifo #(.ADDR_WIDTH(12), .DROP_BAD_FRAME(1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tuser      (s_axis_tuser),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser),
    .status_overflow   (status_overflow),
    .status_bad_frame  (status_bad_frame),
    .status_good_frame (status_good_frame),
    .status_fill       (status_fill)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_good = 0, n_badf = 0, n_ovf = 0;
  int          hold_err = 0;
  int          last_in_cyc = 0, first_v_cyc = -100;
  logic        arm_lat = 1'b0;
  logic        rand_rdy = 1'b0;
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [9:0]  prev_w = '0;
  logic [9:0]  q[$];
  int          g0, b0, o0;

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) m_axis_tready = ($urandom_range(0, 1) == 1);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r &&
          (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} != prev_w))
        hold_err++;
      if (arm_lat && m_axis_tvalid) begin
        first_v_cyc = cyc;
        arm_lat     = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (status_good_frame) n_good++;
      if (status_bad_frame)  n_badf++;
      if (status_overflow)   n_ovf++;
      prev_v = m_axis_tvalid;
      prev_r = m_axis_tready;
      prev_w = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input int len, input int base, input logic user);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(base + i);
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == len - 1) ? user : 1'b0;
      if (i == len - 1) last_in_cyc = cyc;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  // Expected frame: bytes base..base+len-1, tlast on the final byte only.
  task automatic check_frame(input string tag, input int len, input int base);
    int errs = 0;
    logic [9:0] exp_w;
    chk_eq({tag, "_count"}, q.size(), len);
    for (int i = 0; i < len && i < q.size(); i++) begin
      exp_w = {1'b0, (i == len - 1), 8'(base + i)};
      if (q[i] !== exp_w) errs++;
    end
    chk_eq({tag, "_data"}, errs, 0);
  endtask

  task automatic snap;
    g0 = n_good; b0 = n_badf; o0 = n_ovf;
    q.delete();
  endtask

  initial begin
    int errs;
    wait_cycles(3); #1;
    chk_eq("reset_out", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, 0);
    chk_eq("reset_status", {status_overflow, status_bad_frame, status_good_frame, status_fill}, 0);
    rst_n = 1'b1;
    wait_cycles(2); #1;

    // 64-byte good frame, tready high
    m_axis_tready = 1'b1;
    snap();
    arm_lat = 1'b1;
    send_frame(64, 0, 1'b0);
    wait_cycles(80);
    check_frame("t1", 64, 0);
    chk_eq("t1_latency", first_v_cyc - last_in_cyc, 2);
    chk_eq("t1_good", n_good - g0, 1);
    chk_eq("t1_fill", status_fill, 0);

    // bad frame dropped, then a good one passes
    snap();
    send_frame(60, 8'h20, 1'b1);
    wait_cycles(80);
    chk_eq("t2_bad_out", q.size(), 0);
    chk_eq("t2_badpulse", n_badf - b0, 1);
    chk_eq("t2_nogood", n_good - g0, 0);
    snap();
    send_frame(64, 8'h40, 1'b0);
    wait_cycles(80);
    check_frame("t2_good", 64, 8'h40);

    // full-depth frame commits, next frame overflows
    m_axis_tready = 1'b0;
    snap();
    send_frame(4096, 0, 1'b0);
    send_frame(10, 8'hA0, 1'b0);
    wait_cycles(10); #1;
    chk_eq("t3_fill", status_fill, 4096);
    chk_eq("t3_ovf", n_ovf - o0, 1);
    chk_eq("t3_good", n_good - g0, 1);
    chk_eq("t3_valid_stall", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    wait_cycles(4200); #1;
    check_frame("t3", 4096, 0);
    chk_eq("t3_fill_end", status_fill, 0);

    // oversized frame into empty FIFO
    snap();
    send_frame(5000, 0, 1'b0);
    wait_cycles(20); #1;
    chk_eq("t4_out", q.size(), 0);
    chk_eq("t4_ovf", n_ovf - o0, 1);
    chk_eq("t4_good", n_good - g0, 0);
    chk_eq("t4_fill", status_fill, 0);

    // 8192 single-byte frames with random tready
    snap();
    rand_rdy = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(i);
      s_axis_tlast  = 1'b1;
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      @(posedge clk);
    end
    for (int c = 0; c < 30000 && q.size() < 8192; c++) @(posedge clk);
    rand_rdy = 1'b0;
    wait_cycles(2); #1;
    m_axis_tready = 1'b1;
    chk_eq("t5_count", q.size(), 8192);
    errs = 0;
    for (int i = 0; i < 8192 && i < q.size(); i++)
      if (q[i] !== {2'b01, 8'(i)}) errs++;
    chk_eq("t5_data", errs, 0);
    chk_eq("t5_good", n_good - g0, 8192);
    chk_eq("t5_ovf", n_ovf - o0, 0);

    // reset mid-frame with committed frames pending
    m_axis_tready = 1'b0;
    send_frame(64, 8'h10, 1'b0);
    send_frame(64, 8'h50, 1'b0);
    wait_cycles(5); #1;
    chk_eq("t6_pending_valid", m_axis_tvalid, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(8'hC0 + i);
      s_axis_tlast  = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    chk_eq("t6_rst_valid", m_axis_tvalid, 0);
    wait_cycles(3); #1;
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    snap();
    wait_cycles(10); #1;
    chk_eq("t6_out_after_rst", q.size(), 0);
    chk_eq("t6_fill", status_fill, 0);
    send_frame(64, 8'h80, 1'b0);
    wait_cycles(80);
    check_frame("t6", 64, 8'h80);

    chk_eq("axi_hold", hold_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
